// File: rtl/mips_muldiv.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers; mul/div results land
// WIDTH+1 edges after the start edge, MTHI/MTLO in one edge; start is dropped while busy.
module mips_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             cancel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   // rem holds the multiply accumulator or the divide partial remainder;
   // quo holds the multiplier or the dividend/quotient; dvs the multiplicand or divisor.
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             is_div_q, is_div_d;
   logic             neg_q, neg_d;
   logic             rsign_q, rsign_d;

   logic             a_neg, b_neg;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shl;
   logic [WIDTH:0]   div_diff;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rsign_d  = rsign_q;

      a_neg    = 1'b0;
      b_neg    = 1'b0;
      mul_sum  = rem_q + {1'b0, (quo_q[0] ? dvs_q : {WIDTH{1'b0}})};
      div_shl  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      div_diff = div_shl - {1'b0, dvs_q};
      prod     = {rem_q[WIDTH-1:0], quo_q};
      prod_fix = neg_q ? -prod : prod;
      quo_fix  = neg_q ? -quo_q : quo_q;
      rem_fix  = rsign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

      case (state_q)
         S_IDLE: begin
            if (start && !cancel) begin
               case (op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     a_neg    = ~op[0] & a[WIDTH-1];
                     b_neg    = ~op[0] & b[WIDTH-1];
                     // 0x80000000 negates to itself and is then read as unsigned.
                     quo_d    = a_neg ? -a : a;
                     dvs_d    = b_neg ? -b : b;
                     rem_d    = '0;
                     is_div_d = op[1];
                     neg_d    = a_neg ^ b_neg;
                     rsign_d  = a_neg;
                     count_d  = CW'(WIDTH - 1);
                     busy_d   = 1'b1;
                     state_d  = S_RUN;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (cancel) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               if (is_div_q) begin
                  if (div_shl >= {1'b0, dvs_q}) begin
                     rem_d = div_diff;
                     quo_d = {quo_q[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_d = div_shl;
                     quo_d = {quo_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  rem_d = {1'b0, mul_sum[WIDTH:1]};
                  quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
               end
               count_d = count_q - CW'(1);
               if (count_q == '0) begin
                  state_d = S_FIN;
               end
            end
         end
         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (!cancel) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  // Divide by zero: all-ones quotient, remainder restores the dividend.
                  lo_d = (dvs_q == '0) ? {WIDTH{1'b1}} : quo_fix;
                  hi_d = rem_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rsign_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rsign_q  <= rsign_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
